// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared definitions for the measurement-link frame receiver.
//   - Header and trailer characters for each of the three frame kinds
//   - kind_e: which result register a frame addresses
//   - rx_state_e: per-byte serial receiver states
//   - frame_state_e: frame decoder states
//   - maj3(): 2-of-3 vote used by the optional oversampling path
//   - trailer_of(): expected trailer character for a frame kind
package uart_frame_pkg;

  localparam logic [7:0] HDR_PINLV = 8'h74;  // 't'
  localparam logic [7:0] TRL_PINLV = 8'h78;  // 'x'
  localparam logic [7:0] HDR_CYCLE = 8'h63;  // 'c'
  localparam logic [7:0] TRL_CYCLE = 8'h79;  // 'y'
  localparam logic [7:0] HDR_DUTY  = 8'h64;  // 'd'
  localparam logic [7:0] TRL_DUTY  = 8'h75;  // 'u'

  typedef enum logic [1:0] {
    KIND_PINLV = 2'd0,
    KIND_CYCLE = 2'd1,
    KIND_DUTY  = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    F_HDR = 3'd0,
    F_B3  = 3'd1,
    F_B2  = 3'd2,
    F_B1  = 3'd3,
    F_B0  = 3'd4,
    F_TRL = 3'd5
  } frame_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [7:0] trailer_of(input kind_e k);
    logic [7:0] t;
    case (k)
      KIND_PINLV: t = TRL_PINLV;
      KIND_CYCLE: t = TRL_CYCLE;
      KIND_DUTY:  t = TRL_DUTY;
      default:    t = 8'h00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/uart_frame_rx_byte.sv
// uart_rx_byte: 8N1 serial byte receiver.
//   Synchronizes the asynchronous line, detects the start-bit falling edge,
//   then samples start, 8 data bits (LSB first) and stop at bit centres.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   uart_rx          serial line, idle high
//   byte_data[7:0]   received byte, valid while byte_vld is high
//   byte_vld         one-cycle pulse: byte received with a good stop bit
//   byte_ferr        one-cycle pulse: stop bit sampled low, byte discarded
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 vote around each bit
//   centre (decisions move one cycle later; needs BPS_DIV >= 8).
module uart_rx_byte
  import uart_frame_pkg::*;
#(
  parameter int BPS_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_vld,
  output logic       byte_ferr
);

  localparam logic [15:0] BIT_LAST_C = 16'(BPS_DIV - 1);
`ifdef UART_RX_MAJORITY_EN
  // One extra cycle in the start phase lets the vote see centre+1.
  localparam logic [15:0] START_LAST_C = 16'(BPS_DIV / 2);
`else
  localparam logic [15:0] START_LAST_C = 16'(BPS_DIV / 2 - 1);
`endif

  logic       sync1_r;
  logic       sync2_r;
  logic       d1_r;
`ifdef UART_RX_MAJORITY_EN
  logic       d2_r;
`endif
  logic       fall_s;
  logic       sample_s;
  rx_state_e  state_r;
  logic [15:0] cnt_r;
  logic [2:0] bit_idx_r;
  logic [7:0] shift_r;

  // Two-flop synchronizer plus delayed copies for edge detect and voting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      d1_r    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      d2_r    <= 1'b1;
`endif
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      d1_r    <= sync2_r;
`ifdef UART_RX_MAJORITY_EN
      d2_r    <= d1_r;
`endif
    end
  end

  assign fall_s = d1_r & ~sync2_r;

  // Bit decision value: either the centre sample or the vote around it.
  always_comb begin
`ifdef UART_RX_MAJORITY_EN
    sample_s = maj3(sync2_r, d1_r, d2_r);
`else
    sample_s = sync2_r;
`endif
  end

  // Byte FSM: start qualification, data shift, stop check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RX_IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      byte_data <= 8'h00;
      byte_vld  <= 1'b0;
      byte_ferr <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      byte_ferr <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (fall_s) begin
            cnt_r   <= 16'd0;
            state_r <= RX_START;
          end else begin
            cnt_r <= 16'd0;
          end
        end
        RX_START: begin
          if (cnt_r == START_LAST_C) begin
            cnt_r <= 16'd0;
            // A line already back high at mid start bit is a glitch.
            if (!sample_s) begin
              bit_idx_r <= 3'd0;
              state_r   <= RX_DATA;
            end else begin
              state_r <= RX_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_LAST_C) begin
            cnt_r   <= 16'd0;
            shift_r <= {sample_s, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_LAST_C) begin
            cnt_r <= 16'd0;
            // Return to idle at mid stop bit so a back-to-back start is caught.
            state_r <= RX_IDLE;
            if (sample_s) begin
              byte_vld  <= 1'b1;
              byte_data <= shift_r;
            end else begin
              byte_ferr <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= RX_IDLE;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver and 6-byte frame decoder for the measurement link.
//   Frame: header, 4 data bytes MSB first, trailer.
//   't'..'x' -> pinlv, 'c'..'y' -> cycle, 'd'..'u' -> duty_cycle.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   uart_rx                serial line, idle high, asynchronous
//   pinlv/cycle/duty_cycle last successfully decoded values
//   pinlv_vld/cycle_vld/duty_vld  one-cycle pulse when the register updates
//   frame_err              one-cycle pulse on an aborted frame
// Build option: UART_RX_MAJORITY_EN (see uart_rx_byte).
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int BPS_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [31:0] pinlv,
  output logic [31:0] cycle,
  output logic [31:0] duty_cycle,
  output logic        pinlv_vld,
  output logic        cycle_vld,
  output logic        duty_vld,
  output logic        frame_err
);

  logic [7:0]   byte_data_s;
  logic         byte_vld_s;
  logic         byte_ferr_s;
  frame_state_e fstate_r;
  kind_e        kind_r;
  logic [31:0]  shreg_r;

  uart_rx_byte #(.BPS_DIV(BPS_DIV)) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .byte_data (byte_data_s),
    .byte_vld  (byte_vld_s),
    .byte_ferr (byte_ferr_s)
  );

  // Frame FSM: header select, data assembly, trailer check and output load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_r   <= F_HDR;
      kind_r     <= KIND_PINLV;
      shreg_r    <= 32'h0000_0000;
      pinlv      <= 32'h0000_0000;
      cycle      <= 32'h0000_0000;
      duty_cycle <= 32'h0000_0000;
      pinlv_vld  <= 1'b0;
      cycle_vld  <= 1'b0;
      duty_vld   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pinlv_vld <= 1'b0;
      cycle_vld <= 1'b0;
      duty_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (byte_ferr_s) begin
        // A framing error only matters once a frame has started.
        if (fstate_r != F_HDR) begin
          frame_err <= 1'b1;
          fstate_r  <= F_HDR;
        end else begin
          fstate_r <= F_HDR;
        end
      end else if (byte_vld_s) begin
        case (fstate_r)
          F_HDR: begin
            case (byte_data_s)
              HDR_PINLV: begin kind_r <= KIND_PINLV; fstate_r <= F_B3; end
              HDR_CYCLE: begin kind_r <= KIND_CYCLE; fstate_r <= F_B3; end
              HDR_DUTY:  begin kind_r <= KIND_DUTY;  fstate_r <= F_B3; end
              default:   fstate_r <= F_HDR;
            endcase
          end
          F_B3: begin shreg_r[31:24] <= byte_data_s; fstate_r <= F_B2;  end
          F_B2: begin shreg_r[23:16] <= byte_data_s; fstate_r <= F_B1;  end
          F_B1: begin shreg_r[15:8]  <= byte_data_s; fstate_r <= F_B0;  end
          F_B0: begin shreg_r[7:0]   <= byte_data_s; fstate_r <= F_TRL; end
          F_TRL: begin
            fstate_r <= F_HDR;
            // A wrong trailer is consumed here, never re-read as a header.
            if (byte_data_s == trailer_of(kind_r)) begin
              case (kind_r)
                KIND_PINLV: begin pinlv      <= shreg_r; pinlv_vld <= 1'b1; end
                KIND_CYCLE: begin cycle      <= shreg_r; cycle_vld <= 1'b1; end
                KIND_DUTY:  begin duty_cycle <= shreg_r; duty_vld  <= 1'b1; end
                default:    frame_err <= 1'b1;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: fstate_r <= F_HDR;
        endcase
      end else begin
        fstate_r <= fstate_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

  localparam int BPS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] pinlv, cycle, duty_cycle;
  logic        pinlv_vld, cycle_vld, duty_vld, frame_err;

  uart_frame_rx #(.BPS_DIV(BPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .pinlv      (pinlv),
    .cycle      (cycle),
    .duty_cycle (duty_cycle),
    .pinlv_vld  (pinlv_vld),
    .cycle_vld  (cycle_vld),
    .duty_vld   (duty_vld),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Expected strobe event: kind 0 pinlv, 1 cycle, 2 duty, 3 frame error,
  // with the register values expected after it.
  typedef struct {
    int          kind;
    logic [31:0] p;
    logic [31:0] c;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  pend_q[$];
  logic [31:0] m_p = 32'd0, m_c = 32'd0, m_d = 32'd0;
  int          checks = 0;
  int          errors = 0;

  // Reference model: a frame is just a list of 6 collected bytes.
  task automatic model_byte(input logic [7:0] b, input bit ferr);
    ev_t         e;
    logic [31:0] v;
    bit          ok;
    if (ferr) begin
      if (pend_q.size() > 0) begin
        pend_q.delete();
        e.kind = 3; e.p = m_p; e.c = m_c; e.d = m_d;
        exp_q.push_back(e);
      end
    end else if (pend_q.size() == 0) begin
      if (b == 8'h74 || b == 8'h63 || b == 8'h64) pend_q.push_back(b);
    end else begin
      pend_q.push_back(b);
      if (pend_q.size() == 6) begin
        v  = {pend_q[1], pend_q[2], pend_q[3], pend_q[4]};
        ok = 1'b1;
        if (pend_q[0] == 8'h74 && b == 8'h78) begin m_p = v; e.kind = 0; end
        else if (pend_q[0] == 8'h63 && b == 8'h79) begin m_c = v; e.kind = 1; end
        else if (pend_q[0] == 8'h64 && b == 8'h75) begin m_d = v; e.kind = 2; end
        else ok = 1'b0;
        if (!ok) e.kind = 3;
        e.p = m_p; e.c = m_c; e.d = m_d;
        exp_q.push_back(e);
        pend_q.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 byte; the model sees it before the DUT samples the stop bit.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BPS) @(negedge clk);
    end
    model_byte(b, !stop_ok);
    uart_rx = stop_ok;
    repeat (BPS) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (BPS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [31:0] v, input logic [7:0] t);
    send_byte(h, 1'b1);
    send_byte(v[31:24], 1'b1);
    send_byte(v[23:16], 1'b1);
    send_byte(v[15:8], 1'b1);
    send_byte(v[7:0], 1'b1);
    send_byte(t, 1'b1);
  endtask

  // Scoreboard monitor: every strobe pops one expected event.
  always @(negedge clk) begin
    int  n;
    int  ka;
    ev_t e;
    n = int'(pinlv_vld) + int'(cycle_vld) + int'(duty_vld) + int'(frame_err);
    if (n > 0) begin
      checks++;
      ka = pinlv_vld ? 0 : cycle_vld ? 1 : duty_vld ? 2 : 3;
      if (n > 1) begin
        errors++;
        $display("FAIL strobe_overlap: %0d strobes together, expected 1", n);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: kind %0d with nothing expected", ka);
      end else begin
        e = exp_q.pop_front();
        if (ka != e.kind || pinlv !== e.p || cycle !== e.c || duty_cycle !== e.d) begin
          errors++;
          $display("FAIL event: got kind %0d p=%h c=%h d=%h expected kind %0d p=%h c=%h d=%h",
                   ka, pinlv, cycle, duty_cycle, e.kind, e.p, e.c, e.d);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pinlv"}, pinlv, 32'd0);
    chk({tag, "_cycle"}, cycle, 32'd0);
    chk({tag, "_duty"}, duty_cycle, 32'd0);
    chk({tag, "_strobes"}, {28'd0, pinlv_vld, cycle_vld, duty_vld, frame_err}, 32'd0);
  endtask

  initial begin
    logic [7:0]  hdr, trl, junk;
    logic [31:0] val;
    int          k;

    repeat (5) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(10);

    // Basic pinlv frame
    send_frame(8'h74, 32'h1234_5678, 8'h78);
    idle(10);
    chk("t1_pinlv", pinlv, 32'h1234_5678);
    chk("t1_cycle", cycle, 32'd0);
    chk("t1_duty", duty_cycle, 32'd0);

    // Two frames with no idle gap
    send_frame(8'h63, 32'd500, 8'h79);
    send_frame(8'h64, 32'd50, 8'h75);
    idle(10);
    chk("t2_cycle", cycle, 32'd500);
    chk("t2_duty", duty_cycle, 32'd50);

    // Wrong trailer, then a good frame
    send_frame(8'h74, 32'hAABB_CCDD, 8'h79);
    idle(10);
    chk("t3_pinlv_held", pinlv, 32'h1234_5678);
    send_frame(8'h74, 32'hCAFE_0001, 8'h78);
    idle(10);
    chk("t3_pinlv_new", pinlv, 32'hCAFE_0001);

    // Short low glitch on the idle line
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    send_frame(8'h63, 32'h0BAD_F00D, 8'h79);
    idle(10);
    chk("t4_cycle", cycle, 32'h0BAD_F00D);

    // Stop bit low on the 3rd data byte, then a lone 'A' in header state
    send_byte(8'h63, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h41, 1'b1);
    idle(20);
    chk("t5_cycle_held", cycle, 32'h0BAD_F00D);

    // Reset in the middle of the 4th byte of a 'd' frame
    send_byte(8'h64, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    uart_rx = 1'b0;
    repeat (BPS) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BPS) @(negedge clk);
    rst_n = 1'b0;
    pend_q.delete();
    m_p = 32'd0; m_c = 32'd0; m_d = 32'd0;
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk_all_zero("t6_reset");
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h64, 32'h0000_0032, 8'h75);
    idle(10);
    chk("t6_duty", duty_cycle, 32'h0000_0032);

    // Randomized frames with junk bytes, bad trailers and random gaps
    for (int f = 0; f < 22; f++) begin
      k   = $urandom_range(2, 0);
      hdr = (k == 0) ? 8'h74 : (k == 1) ? 8'h63 : 8'h64;
      trl = (k == 0) ? 8'h78 : (k == 1) ? 8'h79 : 8'h75;
      if ($urandom_range(5, 0) == 0) trl = 8'($urandom);
      val = $urandom;
      if ($urandom_range(3, 0) == 0) begin
        junk = 8'($urandom);
        send_byte(junk, 1'b1);
      end
      send_frame(hdr, val, trl);
      idle($urandom_range(20, 0));
    end

    idle(60);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_pinlv", pinlv, m_p);
    chk("final_cycle", cycle, m_c);
    chk("final_duty", duty_cycle, m_d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
